ram_march_bist: RTL and testbench

- Built-in self-test controller for the team's 64x8 dual-port RAM.
- Drives one RAM port (address, write data, write enable) and consumes that port's registered read data.
- Runs a March C- algorithm with 0x00/0xFF data backgrounds and reports pass/fail with first-failure location.
- Sits directly upstream of the RAM in the test/bring-up path. Functional logic owns the RAM when busy is low.

---
 rtl/ram_march_bist.sv | 123 ++++++++++++
 tb/tb_ram_march_bist.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_march_bist.sv
// March C- built-in self-test controller for the 64x8 dual-port RAM.
// Drives one RAM port and reports pass/fail with the first failing location.
module ram_march_bist #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [1:0]        state;
    logic [2:0]        elem;
    logic [ADDR_W-1:0] addr;
    logic              chk;

    logic              run;
    logic              down;
    logic              wr_one;
    logic              rd_one;
    logic              last;
    logic              mismatch;
    logic [DATA_W-1:0] exp_q;

    // Decode RAM controls and element properties from registered state only
    always_comb begin
        run      = (state == S_RUN);
        down     = (elem == 3'd3) || (elem == 3'd4);
        wr_one   = (elem == 3'd1) || (elem == 3'd3);
        rd_one   = (elem == 3'd2) || (elem == 3'd4);
        exp_q    = rd_one ? '1 : '0;
        last     = down ? (addr == '0) : (addr == ADDR_MAX);
        ram_we   = run && ((elem == 3'd0) || (chk && (elem != 3'd5)));
        ram_data = (run && chk && wr_one) ? '1 : '0;
        ram_addr = run ? addr : '0;
        busy     = run;
        done     = (state == S_DONE);
        mismatch = run && chk && (elem != 3'd0) && (ram_q != exp_q);
    end

    // Sequencer: walk elements and addresses, capture the first mismatch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            elem      <= '0;
            addr      <= '0;
            chk       <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
        end else begin
            unique case (1'b1)
                (state == S_IDLE): begin
                    if (start) begin
                        state     <= S_RUN;
                        elem      <= '0;
                        addr      <= '0;
                        chk       <= 1'b0;
                        pass      <= 1'b0;
                        fail      <= 1'b0;
                        fail_addr <= '0;
                        fail_elem <= '0;
                    end
                end
                (state == S_RUN): begin
                    if (mismatch) begin
                        fail      <= 1'b1;
                        fail_addr <= addr;
                        fail_elem <= elem;
                        state     <= S_DONE;
                    end else if ((elem == 3'd0) || chk) begin
                        chk <= 1'b0;
                        if (last) begin
                            if (elem == 3'd5) begin
                                pass  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                elem <= elem + 3'd1;
                                // elements 3 and 4 walk downward
                                if ((elem == 3'd2) || (elem == 3'd3)) begin
                                    addr <= ADDR_MAX;
                                end else begin
                                    addr <= '0;
                                end
                            end
                        end else if (down) begin
                            addr <= addr - ADDR_ONE;
                        end else begin
                            addr <= addr + ADDR_ONE;
                        end
                    end else begin
                        chk <= 1'b1;
                    end
                end
                (state == S_DONE): begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_march_bist.sv
// Self-checking bench for ram_march_bist with a fault-injecting RAM model.
// Expected schedule and results come from a March C- operation table.
module tb_ram_march_bist;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam int NOPS  = 704;

    typedef struct {
        bit             we;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        bit             chk;
        logic [DW-1:0]  exp;
        int             elem;
    } op_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_we;
    logic [DW-1:0] ram_q = '0;
    logic          busy;
    logic          done;
    logic          pass;
    logic          fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;

    int checks   = 0;
    int failures = 0;

    op_t ops[$];
    logic [AW-1:0] alog [NOPS+2];

    logic [DW-1:0] mem  [DEPTH];
    int            rcnt [DEPTH];
    int            fkind;
    logic [AW-1:0] faddr;
    logic [DW-1:0] fmask;
    int            fcnt;

    ram_march_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_we    (ram_we),
        .ram_q     (ram_q),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem)
    );

    always #5 clk = ~clk;

    // fault kinds: 1 stuck-at-1 bit, 2 no 1->0 transition, 3 corrupt nth read
    function automatic logic [DW-1:0] f_write(input logic [AW-1:0] a,
                                              input logic [DW-1:0] old,
                                              input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
        if (a == faddr && fkind == 1) r = d | fmask;
        if (a == faddr && fkind == 2) r = d | old;
        return r;
    endfunction

    function automatic logic [DW-1:0] f_read(input logic [AW-1:0] a,
                                             input logic [DW-1:0] v,
                                             input int n);
        logic [DW-1:0] r;
        r = v;
        if (a == faddr && fkind == 1) r = v | fmask;
        if (a == faddr && fkind == 3 && n == fcnt) r = v ^ fmask;
        return r;
    endfunction

    // Registered-read RAM port; ram_q holds during writes
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= f_write(ram_addr, mem[ram_addr], ram_data);
        end else if (busy) begin
            rcnt[ram_addr] <= rcnt[ram_addr] + 1;
            ram_q <= f_read(ram_addr, mem[ram_addr], rcnt[ram_addr] + 1);
        end
    end

    task automatic build_ops();
        op_t o;
        int a;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < DEPTH; k++) begin
                a = (e == 3 || e == 4) ? DEPTH - 1 - k : k;
                o.addr = AW'(a);
                o.elem = e;
                if (e == 0) begin
                    o.we = 1; o.data = '0; o.chk = 0; o.exp = '0;
                    ops.push_back(o);
                end else begin
                    o.we = 0; o.data = '0; o.chk = 0; o.exp = '0;
                    ops.push_back(o);
                    o.we   = (e != 5);
                    o.data = (e == 1 || e == 3) ? '1 : '0;
                    o.chk  = 1;
                    o.exp  = (e == 2 || e == 4) ? '1 : '0;
                    ops.push_back(o);
                end
            end
        end
    endtask

    task automatic setup(input int kind, input int a, input int b,
                         input int n, input bit rnd);
        fkind = kind;
        faddr = AW'(a);
        fmask = DW'(1 << b);
        fcnt  = n;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]  = rnd ? DW'($urandom) : '0;
            rcnt[i] = 0;
        end
    endtask

    task automatic predict(output bit pf, output int pe,
                           output int pa, output int edc);
        logic [DW-1:0] pm [DEPTH];
        int            pn [DEPTH];
        logic [DW-1:0] q;
        int            a;
        for (int i = 0; i < DEPTH; i++) begin
            pm[i] = mem[i];
            pn[i] = 0;
        end
        q = '0; pf = 0; pe = 0; pa = 0; edc = NOPS + 1;
        for (int i = 0; i < NOPS && !pf; i++) begin
            a = int'(ops[i].addr);
            if (ops[i].chk && q !== ops[i].exp) begin
                pf = 1; pe = ops[i].elem; pa = a; edc = i + 2;
            end else if (ops[i].we) begin
                pm[a] = f_write(ops[i].addr, pm[a], ops[i].data);
            end else begin
                pn[a]++;
                q = f_read(ops[i].addr, pm[a], pn[a]);
            end
        end
    endtask

    task automatic run_march(input string name, input bit hold);
        bit pf;
        int pe, pa, edc, serr, fc;
        predict(pf, pe, pa, edc);
        serr = 0; fc = 0;
        start = 1'b1;
        for (int c = 1; c <= edc + 1; c++) begin
            @(posedge clk); #1;
            if (!hold && c == 1) start = 1'b0;
            alog[c] = ram_addr;
            if (c < edc) begin
                if (busy !== 1'b1 || done !== 1'b0 ||
                    ram_we !== ops[c-1].we || ram_addr !== ops[c-1].addr ||
                    ram_data !== ops[c-1].data) begin
                    if (serr == 0) fc = c;
                    serr++;
                end
            end else if (c == edc) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL %s end: cycle %0d done=%b busy=%b, required done=1 busy=0",
                             name, c, done, busy);
                end
                checks++;
                if (fail !== pf || pass !== !pf) begin
                    failures++;
                    $display("FAIL %s verdict: pass=%b fail=%b, required pass=%b fail=%b",
                             name, pass, fail, !pf, pf);
                end
                checks++;
                if (fail_addr !== AW'(pa) || fail_elem !== 3'(pe)) begin
                    failures++;
                    $display("FAIL %s loc: fail_addr=%0h fail_elem=%0d, required %0h %0d",
                             name, fail_addr, fail_elem, pa, pe);
                end
            end else begin
                checks++;
                if (done !== 1'b0 || busy !== 1'b0 || ram_we !== 1'b0) begin
                    failures++;
                    $display("FAIL %s idle: done=%b busy=%b we=%b, required 0 0 0",
                             name, done, busy, ram_we);
                end
            end
        end
        checks++;
        if (serr !== 0) begin
            failures++;
            $display("FAIL %s schedule: %0d bad cycles, first at cycle %0d, required 0",
                     name, serr, fc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ram_we !== 0 || ram_addr !== 0 || ram_data !== 0 || busy !== 0 ||
            done !== 0 || pass !== 0 || fail !== 0 || fail_addr !== 0 ||
            fail_elem !== 0) begin
            failures++;
            $display("FAIL reset: we=%b addr=%0h data=%0h busy=%b done=%b pass=%b fail=%b, required all 0",
                     ram_we, ram_addr, ram_data, busy, done, pass, fail);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_clean();
        setup(0, 0, 0, 0, 1);
        run_march("clean", 0);
    endtask

    task automatic test_stuck_at();
        setup(1, 'h2A, 3, 0, 0);
        run_march("stuck_2a_b3", 0);
    endtask

    task automatic test_transition();
        int err;
        setup(2, 'h05, 0, 0, 0);
        run_march("trans_05", 0);
        err = 0;
        for (int k = 0; k <= 58; k++) begin
            if (alog[321 + 2*k] !== AW'(63 - k)) err++;
        end
        checks++;
        if (err !== 0) begin
            failures++;
            $display("FAIL elem3_order: %0d wrong addresses, required 0", err);
        end
    endtask

    task automatic test_elem5_last();
        setup(3, 'h3F, 0, 5, 0);
        run_march("elem5_3f", 0);
    endtask

    task automatic test_start_hold();
        int err;
        setup(0, 0, 0, 0, 1);
        run_march("hold_run1", 1);
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || pass !== 1'b0) begin
            failures++;
            $display("FAIL hold_restart: busy=%b pass=%b, required busy=1 pass=0",
                     busy, pass);
        end
        err = 0;
        for (int c = 708; c <= 1411; c++) begin
            @(posedge clk); #1;
            if (c == 1000) start = 1'b0;
            if (c < 1411 && (done !== 1'b0 || busy !== 1'b1)) err++;
            if (c == 1411) begin
                checks++;
                if (done !== 1'b1 || pass !== 1'b1) begin
                    failures++;
                    $display("FAIL hold_run2_end: done=%b pass=%b, required 1 1",
                             done, pass);
                end
            end
        end
        checks++;
        if (err !== 0) begin
            failures++;
            $display("FAIL hold_run2_busy: %0d bad cycles, required 0", err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int err;
        setup(0, 0, 0, 0, 1);
        err = 0;
        start = 1'b1;
        for (int c = 1; c <= 720; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (c == 300) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL rst_pre: busy=%b, required 1", busy);
                end
                rst_n = 1'b0;
            end else if (c == 301) begin
                checks++;
                if (ram_we !== 0 || ram_addr !== 0 || ram_data !== 0 ||
                    busy !== 0 || done !== 0 || pass !== 0 || fail !== 0 ||
                    fail_addr !== 0 || fail_elem !== 0) begin
                    failures++;
                    $display("FAIL rst_mid: we=%b addr=%0h busy=%b done=%b pass=%b fail=%b, required all 0",
                             ram_we, ram_addr, busy, done, pass, fail);
                end
                rst_n = 1'b1;
            end else if (c > 301 && (done !== 0 || busy !== 0)) begin
                err++;
            end
        end
        checks++;
        if (err !== 0) begin
            failures++;
            $display("FAIL rst_no_done: %0d active cycles, required 0", err);
        end
        run_march("after_reset", 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            setup($urandom_range(0, 3), $urandom_range(0, DEPTH - 1),
                  $urandom_range(0, DW - 1), $urandom_range(1, 6), 1);
            run_march($sformatf("rand%0d_k%0d_a%0h", n, fkind, faddr), 0);
        end
    endtask

    initial begin
        build_ops();
        setup(0, 0, 0, 0, 0);
        test_reset();
        test_clean();
        test_stuck_at();
        test_transition();
        test_elem5_last();
        test_start_hold();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
